// File: rtl/alu_pkg.sv
// Shared opcode indices, FSM state and shift-op encodings for alu_seq.
// ALU_ROTATE_EN widens the opcode to 11 bits (ROL/ROR).
package alu_pkg;

`ifdef ALU_ROTATE_EN
    localparam int CODE_W = 11;
`else
    localparam int CODE_W = 9;
`endif

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_OR  = 2;
    localparam int OP_AND = 3;
    localparam int OP_NOT = 4;
    localparam int OP_SRL = 5;
    localparam int OP_SLL = 6;
    localparam int OP_SRA = 7;
    localparam int OP_ADC = 8;
    localparam int OP_ROL = 9;
    localparam int OP_ROR = 10;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    typedef enum logic [2:0] {SH_SRL, SH_SLL, SH_SRA, SH_ROL, SH_ROR} sh_op_t;

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: working register plus down-counter.
// Rotate steps are only built when ALU_ROTATE_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  sh_op_t           op_i,
    input  logic [CNT_W-1:0] n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] w_q, w_d;
    logic [CNT_W-1:0] cnt_q;
    sh_op_t           op_q;
    logic             c_d;

    always_comb begin
        w_d = w_q;
        c_d = 1'b0;
        case (op_q)
            SH_SRL: begin w_d = {1'b0, w_q[WIDTH-1:1]};        c_d = w_q[0];       end
            SH_SLL: begin w_d = {w_q[WIDTH-2:0], 1'b0};        c_d = w_q[WIDTH-1]; end
            SH_SRA: begin w_d = {w_q[WIDTH-1], w_q[WIDTH-1:1]}; c_d = w_q[0];       end
`ifdef ALU_ROTATE_EN
            SH_ROL: begin w_d = {w_q[WIDTH-2:0], w_q[WIDTH-1]}; c_d = w_q[WIDTH-1]; end
            SH_ROR: begin w_d = {w_q[0], w_q[WIDTH-1:1]};       c_d = w_q[0];       end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_q   <= '0;
            cnt_q <= '0;
            op_q  <= SH_SRL;
        end else if (start_i) begin
            w_q   <= data_i;
            cnt_q <= n_i;
            op_q  <= op_i;
        end else if (cnt_q != '0) begin
            w_q   <= w_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // The final step's value is handed out combinationally so the owner
    // commits it on the same edge the last bit moves.
    assign done_o = (cnt_q == CNT_W'(1));
    assign res_o  = w_d;
    assign cout_o = c_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered flags and iterative shifts.
// Define ALU_ROTATE_EN to add ROL/ROR (11-bit code).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  imData,
    input  logic [WIDTH-1:0]  data,
    input  logic [CODE_W-1:0] code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out,
    output logic              carry,
    output logic              zero,
    output logic              neg,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q, zero_q, neg_q, ovf_q;

    logic [CODE_W-1:0] sel;
    logic [SHW-1:0]    n_raw;
    logic [CNT_W-1:0]  n_clamp, sh_n;
    logic [WIDTH-1:0]  b_x, res_d;
    logic [WIDTH:0]    sum;
    logic              cin, c_d, v_d, is_sh, start_sh;
    sh_op_t            sh_op;
    logic              sh_done, sh_cout;
    logic [WIDTH-1:0]  sh_res;

    always_comb begin
        sel     = code & (~code + CODE_W'(1));
        n_raw   = imData[SHW-1:0];
        n_clamp = (n_raw > SHW'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(n_raw);
        b_x     = sel[OP_SUB] ? ~data : data;
        cin     = sel[OP_SUB] | (sel[OP_ADC] & carry_q);
        sum     = {1'b0, imData} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};

        // Defaults cover MOV and any zero-length shift: pass data, keep carry.
        res_d = data;
        c_d   = carry_q;
        v_d   = 1'b0;
        is_sh = 1'b0;
        sh_op = SH_SRL;
        sh_n  = n_clamp;
        if (sel[OP_ADD] | sel[OP_SUB] | sel[OP_ADC]) begin
            res_d = sum[WIDTH-1:0];
            c_d   = sum[WIDTH];
            v_d   = (imData[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != imData[WIDTH-1]);
        end else if (sel[OP_OR]) begin
            res_d = imData | data;
        end else if (sel[OP_AND]) begin
            res_d = imData & data;
        end else if (sel[OP_NOT]) begin
            res_d = ~data;
        end else if (sel[OP_SRL]) begin
            is_sh = 1'b1;
            sh_op = SH_SRL;
        end else if (sel[OP_SLL]) begin
            is_sh = 1'b1;
            sh_op = SH_SLL;
        end else if (sel[OP_SRA]) begin
            is_sh = 1'b1;
            sh_op = SH_SRA;
        end
`ifdef ALU_ROTATE_EN
        else if (sel[OP_ROL] | sel[OP_ROR]) begin
            is_sh = 1'b1;
            sh_op = sel[OP_ROL] ? SH_ROL : SH_ROR;
            sh_n  = CNT_W'(n_raw % SHW'(WIDTH));
        end
`endif
    end

    assign start_sh = (state_q == IDLE) & in_valid & is_sh & (sh_n != '0);

    alu_shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shift (
        .clk_i  (CLK),
        .rst_i  (RST),
        .start_i(start_sh),
        .op_i   (sh_op),
        .n_i    (sh_n),
        .data_i (data),
        .done_o (sh_done),
        .res_o  (sh_res),
        .cout_o (sh_cout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (is_sh && sh_n != '0) begin
                        state_q <= SHIFT;
                    end else begin
                        out_q   <= res_d;
                        carry_q <= c_d;
                        ovf_q   <= v_d;
                        zero_q  <= (res_d == '0);
                        neg_q   <= res_d[WIDTH-1];
                        state_q <= HOLD;
                    end
                end
                SHIFT: if (sh_done) begin
                    out_q   <= sh_res;
                    carry_q <= sh_cout;
                    ovf_q   <= 1'b0;
                    zero_q  <= (sh_res == '0);
                    neg_q   <= sh_res[WIDTH-1];
                    state_q <= HOLD;
                end
                HOLD: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16, default build): directed table,
// reset/backpressure sequences, and random ops against an arithmetic model.
module tb_alu_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] imData, data, out;
    logic [8:0]  code;
    logic        in_valid, in_ready, carry, zero, neg, ovf, out_valid, out_ready;

    always #5 CLK = ~CLK;

    alu_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .imData(imData), .data(data), .code(code),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .carry(carry),
        .zero(zero), .neg(neg), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    int nchk = 0;
    int nerr = 0;
    bit m_carry = 1'b0;

    typedef struct {
        logic [15:0] o;
        bit          c, z, n, v;
        int          lat;
    } res_t;

    typedef struct {
        logic [8:0]  c;
        logic [15:0] a, b, eo;
        bit          ec, ez, en, ev;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic straight from the op definitions.
    function automatic res_t model(input int op, input logic [15:0] a, input logic [15:0] b, input bit cin);
        res_t r;
        int n, sa, sb, s;
        n = int'(a[4:0]);
        if (n > 16) n = 16;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r.o = b; r.c = cin; r.v = 1'b0; r.lat = 0;
        case (op)
            0: begin s = int'(a) + int'(b); r.o = 16'(s); r.c = (s > 65535);
                     r.v = (sa + sb > 32767) || (sa + sb < -32768); end
            1: begin r.o = a - b; r.c = (a >= b);
                     r.v = (sa - sb > 32767) || (sa - sb < -32768); end
            8: begin s = int'(a) + int'(b) + int'(cin); r.o = 16'(s); r.c = (s > 65535);
                     r.v = (sa + sb + int'(cin) > 32767) || (sa + sb + int'(cin) < -32768); end
            2: r.o = a | b;
            3: r.o = a & b;
            4: r.o = ~b;
            5: begin r.o = b >> n;  if (n > 0) begin r.c = b[n-1];  r.lat = n; end end
            6: begin r.o = b << n;  if (n > 0) begin r.c = b[16-n]; r.lat = n; end end
            7: begin r.o = 16'($signed(b) >>> n); if (n > 0) begin r.c = b[n-1]; r.lat = n; end end
            default: ;
        endcase
        r.z = (r.o == 16'h0);
        r.n = r.o[15];
        return r;
    endfunction

    task automatic run_op(input string nm, input logic [8:0] c, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eo, input bit ec, input bit ez, input bit en, input bit ev,
                          input int elat, input int hold);
        int lat;
        @(negedge CLK);
        chk({nm, " in_ready"}, in_ready, 1);
        code = c; imData = a; data = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        code = 9'($urandom); imData = 16'($urandom); data = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " out"}, out, eo);
        chk({nm, " flags c/z/n/v"}, {carry, zero, neg, ovf}, {ec, ez, en, ev});
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            chk({nm, " hold"}, {out_valid, in_ready, carry, zero, neg, ovf, out},
                               {1'b1, 1'b0, ec, ez, en, ev, eo});
        end
        @(negedge CLK); out_ready = 1'b1;
        @(posedge CLK); #1;
        chk({nm, " release"}, {out_valid, in_ready}, 2'b01);
        @(negedge CLK); out_ready = 1'b0;
        m_carry = ec;
    endtask

    vec_t tbl[14];

    initial begin
        res_t r;
        int idx;
        logic [8:0] c, hi;
        logic [15:0] a, b;

        tbl[0]  = '{9'h001, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1, 0};  // ADD overflow
        tbl[1]  = '{9'h002, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0, 0, 0};  // SUB equal
        tbl[2]  = '{9'h100, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0, 0};  // ADC with carry in
        tbl[3]  = '{9'h080, 16'h0004, 16'h8001, 16'hF800, 0, 0, 1, 0, 4};  // SRA n=4
        tbl[4]  = '{9'h020, 16'h0014, 16'h8001, 16'h0000, 1, 1, 0, 0, 16}; // SRL n=20 clamped
        tbl[5]  = '{9'h040, 16'h0000, 16'h8421, 16'h8421, 1, 0, 1, 0, 0};  // SLL n=0
        tbl[6]  = '{9'h000, 16'hFFFF, 16'h1234, 16'h1234, 1, 0, 0, 0, 0};  // MOV
        tbl[7]  = '{9'h003, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 0};  // lowest bit -> ADD
        tbl[8]  = '{9'h004, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 0, 0};  // OR
        tbl[9]  = '{9'h008, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 1, 0, 0};  // AND
        tbl[10] = '{9'h010, 16'h1111, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 0};  // NOT
        tbl[11] = '{9'h040, 16'h0003, 16'hE001, 16'h0008, 1, 0, 0, 0, 3};  // SLL n=3
        tbl[12] = '{9'h002, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 1, 0, 0};  // SUB borrow
        tbl[13] = '{9'h002, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 1, 0};  // SUB overflow

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; code = '0; imData = '0; data = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset state", {out_valid, in_ready, carry, zero, neg, ovf, out}, {1'b0, 1'b1, 4'b0, 16'h0});
        @(negedge CLK); RST = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].eo,
                   tbl[i].ec, tbl[i].ez, tbl[i].en, tbl[i].ev, tbl[i].lat, (i == 3) ? 2 : 0);

        // Backpressure: result held for 5 cycles with out_ready low.
        run_op("backpressure", 9'h001, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0, 0, 5);

        // Reset during an SLL n=10, after a carry-setting add.
        run_op("pre-reset add", 9'h001, 16'hFFFF, 16'h0002, 16'h0001, 1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        code = 9'h040; imData = 16'd10; data = 16'h0FFF; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("shift busy", {out_valid, in_ready}, 2'b00);
        @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        #1;
        chk("abort reset", {out_valid, in_ready, carry, zero, neg, ovf, out}, {1'b0, 1'b1, 4'b0, 16'h0});
        @(negedge CLK); RST = 1'b0;
        m_carry = 1'b0;
        run_op("post-reset add", 9'h001, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 300; k++) begin
            idx = $urandom_range(0, 9);
            if (idx == 9) begin
                c = '0;
            end else begin
                c  = 9'(1 << idx);
                hi = 9'($urandom);
                if ($urandom_range(0, 1) == 1) c = c | (hi & ~(9'(1 << (idx + 1)) - 9'd1));
            end
            a = 16'($urandom);
            b = 16'($urandom);
            r = model(idx, a, b, m_carry);
            run_op($sformatf("rand%0d op%0d", k, idx), c, a, b, r.o, r.c, r.z, r.n, r.v,
                   r.lat, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 10-bit one-hot ALU. It computes add, subtract, add-with-carry, AND, OR, NOT and three shift operations on `WIDTH`-bit operands. Shifts run iteratively, one bit per cycle, instead of through a barrel shifter. Results and a registered flag set (carry, zero, negative, overflow) are returned through a valid/ready output port; the persistent carry flag feeds ADC for multi-word arithmetic in the CPU datapath.

## Interface
- `WIDTH`, default 16: operand/result width, ≥4.
- `SHW`, default `$clog2(WIDTH)+1`: shift-amount field width taken from `imData`.

- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `imData`  in  WIDTH  operand A; low `SHW` bits are the shift amount for shift ops.
- `data`  in  WIDTH  operand B; value shifted for shift ops.
- `code`  in  9 (11 with `ALU_ROTATE_EN`)  one-hot opcode, bit 0..8 = ADD, SUB, OR, AND, NOT, SRL, SLL, SRA, ADC.
- `in_valid`  in  1  operands/code valid.
- `in_ready`  out  1  block can accept.
- `out`  out  WIDTH  result.
- `carry`, `zero`, `neg`, `ovf`  out  1 each  flags.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts.

## Operation
- FSM states: IDLE, SHIFT, HOLD. `in_ready` = (state==IDLE); a transfer occurs on `in_valid & in_ready`.
- Opcode decode: lowest set bit of `code` wins. All-zero `code` = MOV: `out=data`, carry unchanged.
- ADD: A+B. SUB: A+~B+1. ADC: A+B+carry. All use WIDTH+1-bit sums.
  - carry = bit WIDTH of the sum (SUB: 1 = no borrow).
  - ovf = signed overflow: operand MSBs equal and result MSB differs, with B inverted for SUB.
- OR, AND, NOT (`~data`): ovf=0, carry unchanged.
- SRL/SLL/SRA: `data` shifted by amount n = `imData[SHW-1:0]`.
  - n is clamped to WIDTH.
  - SRA fills with the original MSB.
  - carry = last bit shifted out, or unchanged if n=0.
  - ovf=0.
- zero = (out==0) and neg = out[WIDTH-1] for every op.
- Accept with a non-shift op, or a shift with n=0: result registered at the accept edge, go to HOLD.
- Accept with a shift, n>0: load working register and counter, go to SHIFT. Each cycle shifts one bit and decrements the counter. At counter reaching 0, commit result/flags and go to HOLD.
- HOLD: `out_valid`=1; `out` and flags are stable until `out_ready`. Then go to IDLE.
- `carry` persists across operations until the next carry-writing op.

## Timing
- Reset values: `out`=0, all flags 0, `out_valid`=0, `in_ready`=1, state IDLE.
- Non-shift latency: accept edge T, `out_valid` high after T; earliest next accept T+2.
- Shift by n (1..WIDTH): `out_valid` high after edge T+n.
- Operands are sampled only at the accept edge; later input changes are ignored.
- RST asserted mid-SHIFT or HOLD: operation aborted, outputs return to reset values, carry cleared.
- `out_ready` high while not in HOLD has no effect.

## Configuration
- `ALU_ROTATE_EN` defined:
  - `code` is 11 bits; bit 9 = ROL, bit 10 = ROR, both iterative like the shifts.
  - carry = last bit rotated across; n is taken modulo WIDTH.
  - n≡0 completes in one cycle with carry unchanged.
- `ALU_ROTATE_EN` undefined: `code` is 9 bits; no rotate logic is built.

## Structure
- Package `alu_pkg`: opcode bit-index localparams (`OP_ADD`…`OP_ADC`, `OP_ROL`, `OP_ROR`), the FSM state enum and the `CODE_W` constant.
- Sub-module `alu_shift_unit`: working register, counter and per-cycle one-bit shift/rotate. It takes start/op/n and returns done/result/carry-out. The top level keeps the FSM, arithmetic and flags.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001 → out=0x8000, ovf=1, neg=1, carry=0, zero=0; `out_valid` one cycle after accept.
- SUB 0x0005−0x0005 → out=0, zero=1, carry=1. Then ADC 0xFFFF+0x0000 → out=0x0000, carry=1, zero=1.
- SRA data=0x8001, n=4 → out=0xF800, carry=0, `out_valid` after 4 cycles. SRL n=20 → out=0, cycles=16.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → out/flags stable, `in_ready`=0; release → IDLE next cycle.
- RST asserted on cycle 3 of an SLL n=10 → `out`=0, `out_valid`=0, `in_ready`=1 immediately; next ADD executes normally.
- `code`=0b000000011 → treated as ADD. `code`=0 → out=data, carry unchanged.
